pc_fetch_gen: RTL and testbench

//  Parametrised fetch-stage PC generator; next generation of the IF-stage PC register.

---
 rtl/pc_fetch_gen.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: the fetch-stage PC generator. It holds the fetch PC and presents it to the
// I-side with a valid/ready handshake. A branch redirect that arrives while fetch cannot
// advance is buffered, so it is never lost. The block also flags a misaligned fetch address.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_i           pipeline stall vector; any set bit stalls fetch
//   exception_i       exception/flush redirect to exception_pc_i (highest priority)
//   branch_enable_i   single-cycle branch redirect request to branch_addr_i
//   fetch_ready_i     the I-side accepts pc_o this cycle
//   pc_o, pc_valid_o  fetch request
//   redirect_pend_o   a buffered branch target is waiting
//   exception_type_o  32'h8000_0000 when pc_o is valid and misaligned, otherwise 0
//
// Optional feature, macro PC_PERF_CNT_EN: adds the perf_redirect_o and perf_stall_o
// counters. When the macro is not defined, neither the ports nor the counters exist.
module pc_fetch_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'hBFC0_0000,
  parameter int unsigned STALL_W    = 4,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                exception_i,
  input  logic [ADDR_W-1:0]   exception_pc_i,
  input  logic                branch_enable_i,
  input  logic [ADDR_W-1:0]   branch_addr_i,
  input  logic                fetch_ready_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                pc_valid_o,
  output logic                redirect_pend_o,
  output logic [31:0]         exception_type_o
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]         perf_redirect_o,
  output logic [31:0]         perf_stall_o
`endif
);

  localparam int unsigned OFF_W = $clog2(INST_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                advance;
  logic                redirect_applied;
  logic                misaligned;

  assign advance = pc_valid_o & fetch_ready_i & (stall_i == '0);

  // Next state, pending target and next fetch PC.
  always_comb begin
    state_d          = state_q;
    pend_addr_d      = pend_addr_q;
    pc_d             = pc_o;
    redirect_applied = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!exception_i && branch_enable_i && !advance) begin
          state_d     = ST_PEND;
          pend_addr_d = branch_addr_i;
        end
      end
      ST_PEND: begin
        if (exception_i || advance) begin
          state_d = ST_RUN;
        end else if (branch_enable_i) begin
          pend_addr_d = branch_addr_i;  // the younger branch replaces the buffered one
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // advance is always 0 in BOOT, so a branch pulse during BOOT falls through to hold.
    if (exception_i) begin
      pc_d             = exception_pc_i;
      redirect_applied = 1'b1;
    end else if (state_q == ST_PEND && advance) begin
      pc_d             = pend_addr_q;
      redirect_applied = 1'b1;
    end else if (branch_enable_i && advance) begin
      pc_d             = branch_addr_i;
      redirect_applied = 1'b1;
    end else if (advance) begin
      pc_d = pc_o + ADDR_W'(INST_BYTES);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_o            <= RESET_VEC;
      pend_addr_q     <= '0;
      pc_valid_o      <= 1'b0;
      redirect_pend_o <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_o            <= pc_d;
      pend_addr_q     <= pend_addr_d;
      pc_valid_o      <= (state_d != ST_BOOT);
      redirect_pend_o <= (state_d == ST_PEND);
    end
  end

  // Misalignment flag. With single-byte instructions every address is aligned.
  generate
    if (OFF_W > 0) begin : g_align
      assign misaligned = (pc_o[OFF_W-1:0] != '0);
    end else begin : g_noalign
      assign misaligned = 1'b0;
    end
  endgenerate

  assign exception_type_o = {pc_valid_o & misaligned, 31'b0};

`ifdef PC_PERF_CNT_EN
  // Counters for applied redirects and for stalled valid cycles. Both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirect_o <= '0;
      perf_stall_o    <= '0;
    end else begin
      if (redirect_applied) perf_redirect_o <= perf_redirect_o + 32'd1;
      if (pc_valid_o && !advance) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect_applied;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen. A behavioural model tracks the expected fetch PC and the
// buffered redirect, and the outputs are compared against it after every clock edge.
// The bench also applies a directed scenario with literal expectations, and then
// randomized traffic that includes occasional asynchronous resets.
module tb_pc_fetch_gen;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STALL_W    = 4;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] RST_VEC    = 32'hBFC0_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic [STALL_W-1:0]  stall_i;
  logic                exception_i;
  logic [ADDR_W-1:0]   exception_pc_i;
  logic                branch_enable_i;
  logic [ADDR_W-1:0]   branch_addr_i;
  logic                fetch_ready_i;
  logic [ADDR_W-1:0]   pc_o;
  logic                pc_valid_o;
  logic                redirect_pend_o;
  logic [31:0]         exception_type_o;
`ifdef PC_PERF_CNT_EN
  logic [31:0]         perf_redirect_o;
  logic [31:0]         perf_stall_o;
`endif

  pc_fetch_gen #(
    .ADDR_W(ADDR_W), .RESET_VEC(RST_VEC), .STALL_W(STALL_W), .INST_BYTES(INST_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .exception_i(exception_i),
    .exception_pc_i(exception_pc_i), .branch_enable_i(branch_enable_i),
    .branch_addr_i(branch_addr_i), .fetch_ready_i(fetch_ready_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .redirect_pend_o(redirect_pend_o),
    .exception_type_o(exception_type_o)
`ifdef PC_PERF_CNT_EN
    , .perf_redirect_o(perf_redirect_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: the fetch PC, whether fetch has started, and the buffered branch.
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_pend;
  logic [31:0] m_paddr;
  logic [31:0] m_nredir;
  logic [31:0] m_nstall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_VEC; m_started = 1'b0; m_pend = 1'b0; m_paddr = '0;
    m_nredir = '0; m_nstall = '0;
  endtask

  // Compare every output against the model.
  task automatic compare_model();
    logic [31:0] exp_exc;
    exp_exc = (m_started && (m_pc % INST_BYTES) != 0) ? 32'h8000_0000 : 32'h0;
    chk("pc", pc_o, m_pc);
    chk("valid", 32'(pc_valid_o), 32'(m_started));
    chk("pend", 32'(redirect_pend_o), 32'(m_pend));
    chk("exc_type", exception_type_o, exp_exc);
`ifdef PC_PERF_CNT_EN
    chk("perf_redirect", perf_redirect_o, m_nredir);
    chk("perf_stall", perf_stall_o, m_nstall);
`endif
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step();
    logic        fetch_ok;
    logic [31:0] n_pc;
    logic        n_pend;
    logic [31:0] n_paddr;
    fetch_ok = m_started && fetch_ready_i && (stall_i == 0);
    n_pc = m_pc; n_pend = m_pend; n_paddr = m_paddr;
    if (exception_i) begin
      n_pc = exception_pc_i; n_pend = 1'b0; m_nredir = m_nredir + 1;
    end else if (fetch_ok) begin
      if (m_pend) n_pc = m_paddr;
      else if (branch_enable_i) n_pc = branch_addr_i;
      else n_pc = m_pc + INST_BYTES;
      if (m_pend || branch_enable_i) m_nredir = m_nredir + 1;
      n_pend = 1'b0;
    end else if (branch_enable_i && m_started) begin
      n_pend = 1'b1; n_paddr = branch_addr_i;
    end
    if (m_started && !fetch_ok) m_nstall = m_nstall + 1;
    @(posedge clk); #1;
    m_pc = n_pc; m_pend = n_pend; m_paddr = n_paddr; m_started = 1'b1;
    compare_model();
  endtask

  task automatic idle_inputs();
    stall_i = '0; exception_i = 1'b0; exception_pc_i = '0;
    branch_enable_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc_o, 32'hBFC0_0000);
    chk("reset_valid", 32'(pc_valid_o), 32'd0);
    chk("reset_pend", 32'(redirect_pend_o), 32'd0);
    compare_model();
    rst = 1'b0;

    // Boot and the first two sequential fetch addresses.
    step(); chk("boot_pc", pc_o, 32'hBFC0_0000); chk("boot_valid", 32'(pc_valid_o), 32'd1);
    step(); chk("seq_pc", pc_o, 32'hBFC0_0004);

    // A stall holds the PC.
    stall_i = 4'b0010;
    repeat (3) begin step(); chk("stall_hold", pc_o, 32'hBFC0_0004); end
    stall_i = '0;
    step(); chk("stall_resume", pc_o, 32'hBFC0_0008);

    // A branch during a stall is buffered and then taken.
    stall_i = 4'b0010; branch_enable_i = 1'b1; branch_addr_i = 32'h8000_1000;
    step(); chk("pend_set", 32'(redirect_pend_o), 32'd1); chk("pend_pc", pc_o, 32'hBFC0_0008);
    branch_enable_i = 1'b0;
    step();
    stall_i = '0;
    step(); chk("pend_taken", pc_o, 32'h8000_1000); chk("pend_clr", 32'(redirect_pend_o), 32'd0);

    // An exception while stalled overrides the pending branch.
    stall_i = 4'b0001; branch_enable_i = 1'b1; branch_addr_i = 32'h9000_0000;
    step();
    branch_enable_i = 1'b0; exception_i = 1'b1; exception_pc_i = 32'hBFC0_0380;
    step(); chk("exc_pc", pc_o, 32'hBFC0_0380); chk("exc_pend", 32'(redirect_pend_o), 32'd0);
    exception_i = 1'b0; stall_i = '0;

    // Misaligned and aligned branch targets.
    branch_enable_i = 1'b1; branch_addr_i = 32'h8000_0002;
    step(); chk("misalign", exception_type_o, 32'h8000_0000);
    branch_addr_i = 32'h8000_0010;
    step(); chk("aligned", exception_type_o, 32'h0);

    // Address wrap.
    branch_addr_i = 32'hFFFF_FFFC;
    step(); chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    branch_enable_i = 1'b0;
    step(); chk("wrap", pc_o, 32'h0000_0000);

    // Asynchronous reset taken while a branch is pending.
    stall_i = 4'b1000; branch_enable_i = 1'b1; branch_addr_i = 32'h1234_5678;
    step(); chk("pend_before_rst", 32'(redirect_pend_o), 32'd1);
    branch_enable_i = 1'b0;
    #2 rst = 1'b1; #1;
    model_reset();
    chk("arst_pc", pc_o, 32'hBFC0_0000);
    chk("arst_valid", 32'(pc_valid_o), 32'd0);
    chk("arst_pend", 32'(redirect_pend_o), 32'd0);
    @(posedge clk); #1; compare_model();
    rst = 1'b0; idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      stall_i         = ($urandom_range(0, 3) == 0) ? STALL_W'($urandom_range(1, 15)) : '0;
      fetch_ready_i   = ($urandom_range(0, 4) != 0);
      branch_enable_i = ($urandom_range(0, 4) == 0);
      branch_addr_i   = $urandom;
      if ($urandom_range(0, 3) != 0) branch_addr_i[1:0] = 2'b00;
      exception_i     = ($urandom_range(0, 19) == 0);
      exception_pc_i  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1; #1;
        model_reset();
        compare_model();
        @(posedge clk); #1;
        compare_model();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
